// File: rtl/pwm_pkg.sv
// Shared definitions for the multi-channel PWM generator: channel state
// encoding and the period / phase-step helpers derived from RES and NCH.
package pwm_pkg;

  typedef enum logic [1:0] {
    CH_OFF       = 2'd0,
    CH_RAMP_UP   = 2'd1,
    CH_HOLD      = 2'd2,
    CH_RAMP_DOWN = 2'd3
  } ch_state_t;

  // Number of counter ticks in one PWM period.
  function automatic int period_of(input int res);
    return 1 << res;
  endfunction

  // Phase offset between neighbouring channels (integer division truncates).
  function automatic int phase_step_of(input int res, input int nch);
    return (1 << res) / nch;
  endfunction

endpackage

// File: rtl/pwm_channel.sv
// One PWM channel: enable synchroniser, soft-start/stop ramp FSM, shadow
// compare register (latched on the last count of this channel's own period)
// and the registered PWM output.
//
// tick is a one-clk strobe that advances the shared counter; rtick is the
// one-clk ramp prescaler strobe. Neither carries a handshake: each is
// consumed in the clk it is high.
module pwm_channel
  import pwm_pkg::*;
#(
  parameter int RES       = 10,
  parameter int RAMP_STEP = 1,
  parameter int PHASE_OFS = 0
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           tick,
  input  logic           rtick,
  input  logic [RES-1:0] cnt,
  input  logic           enable,
  input  logic [RES-1:0] duty,
  input  logic           soft_start,
  output logic           pwm_out,
  output logic [1:0]     state
);

  localparam logic [RES-1:0] PC_LAST = '1;
  localparam logic [RES-1:0] OFS     = RES'(PHASE_OFS);
  localparam logic [RES:0]   STEP    = (RES+1)'(RAMP_STEP);

  logic           en_meta, en_s;
  logic [RES-1:0] tgt;
  logic [RES-1:0] duty_actual, duty_actual_d;
  logic [RES-1:0] duty_cmp, cmp_new;
  logic [RES-1:0] pc, pc_next;
  logic [RES:0]   up_sum;
  logic [RES-1:0] up_val, dn_val;
  ch_state_t      state_q, state_d, settle_st;

  assign state   = state_q;
  assign tgt     = en_s ? duty : '0;
  assign pc      = cnt + OFS;
  assign pc_next = pc + 1'b1;
  // The compare value for the new period is taken on the period's last tick.
  assign cmp_new = (pc == PC_LAST) ? duty_actual : duty_cmp;

  // Ramp step arithmetic at RES+1 bits, clamped to the target.
  assign up_sum    = {1'b0, duty_actual} + STEP;
  assign up_val    = (up_sum >= {1'b0, tgt}) ? tgt : up_sum[RES-1:0];
  assign dn_val    = ({1'b0, duty_actual} <= ({1'b0, tgt} + STEP)) ? tgt
                                                                   : duty_actual - STEP[RES-1:0];
  assign settle_st = (tgt == '0) ? CH_OFF : CH_HOLD;

  // Two-flop synchroniser for the asynchronous enable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_meta <= 1'b0;
      en_s    <= 1'b0;
    end else begin
      en_meta <= enable;
      en_s    <= en_meta;
    end
  end

  // Ramp FSM next-state and next duty_actual.
  always_comb begin
    state_d       = state_q;
    duty_actual_d = duty_actual;
    if (!soft_start) begin
      duty_actual_d = tgt;
      state_d       = settle_st;
    end else begin
      case (state_q)
        CH_OFF: begin
          duty_actual_d = '0;
          if (tgt != '0) state_d = CH_RAMP_UP;
        end
        CH_RAMP_UP: begin
          if (tgt < duty_actual)       state_d = CH_RAMP_DOWN;
          else if (tgt == duty_actual) state_d = settle_st;
          else if (rtick) begin
            duty_actual_d = up_val;
            if (up_val == tgt) state_d = CH_HOLD;
          end
        end
        CH_HOLD: begin
          if (tgt > duty_actual)      state_d = CH_RAMP_UP;
          else if (tgt < duty_actual) state_d = CH_RAMP_DOWN;
        end
        CH_RAMP_DOWN: begin
          if (tgt > duty_actual)       state_d = CH_RAMP_UP;
          else if (tgt == duty_actual) state_d = settle_st;
          else if (rtick) begin
            duty_actual_d = dn_val;
            if (dn_val == tgt) state_d = settle_st;
          end
        end
        default: state_d = CH_OFF;
      endcase
    end
  end

  // Ramp FSM state and working duty registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= CH_OFF;
      duty_actual <= '0;
    end else begin
      state_q     <= state_d;
      duty_actual <= duty_actual_d;
    end
  end

  // Shadow compare and output flop, both advanced only on tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      duty_cmp <= '0;
      pwm_out  <= 1'b0;
    end else if (tick) begin
      duty_cmp <= cmp_new;
      pwm_out  <= (cmp_new == PC_LAST) || (pc_next < cmp_new);
    end
  end

endmodule

// File: rtl/pwm_multi_channel.sv
// NCH-channel PWM generator sharing one RES-bit period counter and one ramp
// prescaler. Each channel gets a fixed phase offset when staggering is on.
module pwm_multi_channel
  import pwm_pkg::*;
#(
  parameter int NCH           = 2,
  parameter int RES           = 10,
  parameter int RAMP_DIV      = 9999,
  parameter int RAMP_STEP     = 1,
  parameter int PHASE_STAGGER = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               tick,
  input  logic [NCH-1:0]     enable,
  input  logic [NCH*RES-1:0] duty,
  input  logic [NCH-1:0]     soft_start,
  output logic [NCH-1:0]     pwm_out,
  output logic [NCH-1:0]     ramping,
  output logic               period_start
);

  localparam int             PERIOD     = period_of(RES);
  localparam int             PHASE_STEP = phase_step_of(RES, NCH);
  localparam logic [RES-1:0] CNT_LAST   = RES'(PERIOD - 1);
  localparam int             PW         = (RAMP_DIV < 1) ? 1 : $clog2(RAMP_DIV + 1);
  localparam logic [PW-1:0]  PRESC_LAST = PW'(RAMP_DIV);

  logic [RES-1:0] cnt;
  logic [PW-1:0]  presc;
  logic           rtick;

  assign rtick = (presc == PRESC_LAST);

  // Shared period counter with natural wrap; flag the wrap to 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt          <= '0;
      period_start <= 1'b0;
    end else begin
      period_start <= tick && (cnt == CNT_LAST);
      if (tick) cnt <= cnt + 1'b1;
    end
  end

  // Free-running ramp prescaler, independent of channel activity.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     presc <= '0;
    else if (rtick) presc <= '0;
    else            presc <= presc + 1'b1;
  end

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    logic [1:0] st;

    pwm_channel #(
      .RES       (RES),
      .RAMP_STEP (RAMP_STEP),
      .PHASE_OFS ((PHASE_STAGGER != 0) ? g * PHASE_STEP : 0)
    ) u_ch (
      .clk        (clk),
      .rst_n      (rst_n),
      .tick       (tick),
      .rtick      (rtick),
      .cnt        (cnt),
      .enable     (enable[g]),
      .duty       (duty[g*RES +: RES]),
      .soft_start (soft_start[g]),
      .pwm_out    (pwm_out[g]),
      .state      (st)
    );

    assign ramping[g] = (st == CH_RAMP_UP) || (st == CH_RAMP_DOWN);
  end

endmodule

// File: tb/tb_pwm_multi_channel.sv
// Bench for pwm_multi_channel: directed scenarios plus a randomized phase,
// all outputs compared every cycle against a behavioural model.
module tb_pwm_multi_channel;

  localparam int NCH       = 2;
  localparam int RES       = 4;
  localparam int RAMP_DIV  = 3;
  localparam int RAMP_STEP = 2;
  localparam int PERIOD    = 1 << RES;
  localparam int W         = 2 * NCH + 1;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               tick = 1'b0;
  logic [NCH-1:0]     enable = '0;
  logic [NCH*RES-1:0] duty = '0;
  logic [NCH-1:0]     soft_start = '0;
  logic [NCH-1:0]     pwm_out;
  logic [NCH-1:0]     ramping;
  logic               period_start;

  int n_cmp = 0;
  int n_bad = 0;
  logic [W-1:0] exp_q[$];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

  pwm_multi_channel #(
    .NCH(NCH), .RES(RES), .RAMP_DIV(RAMP_DIV), .RAMP_STEP(RAMP_STEP), .PHASE_STAGGER(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .tick(tick), .enable(enable), .duty(duty),
    .soft_start(soft_start), .pwm_out(pwm_out), .ramping(ramping),
    .period_start(period_start)
  );

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Integer model of the period/phase arithmetic and of the ramp as
  // "move toward target by RAMP_STEP per prescaler strobe once moving".
  int m_cnt, m_presc, m_tgt, m_pc;
  int m_meta[NCH], m_ens[NCH], m_da[NCH], m_cmp[NCH];
  bit m_up[NCH];
  bit m_rt;
  logic [NCH-1:0] m_pwm, m_ramp;
  logic m_ps;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cnt = 0; m_presc = 0; m_ps = 1'b0; m_pwm = '0; m_ramp = '0;
      for (int c = 0; c < NCH; c++) begin
        m_meta[c] = 0; m_ens[c] = 0; m_da[c] = 0; m_cmp[c] = 0; m_up[c] = 1'b0;
      end
      exp_q.delete();
    end else begin
      m_rt = (m_presc == RAMP_DIV);
      for (int c = 0; c < NCH; c++) begin
        m_tgt = (m_ens[c] != 0) ? int'(duty[c*RES +: RES]) : 0;
        if (tick) begin
          m_pc = (m_cnt + c * (PERIOD / NCH)) % PERIOD;
          if (m_pc == PERIOD - 1) m_cmp[c] = m_da[c];
          m_pwm[c] = (m_cmp[c] == PERIOD - 1) || (((m_pc + 1) % PERIOD) < m_cmp[c]);
        end
        if (!soft_start[c]) begin
          m_da[c] = m_tgt;
          m_ramp[c] = 1'b0;
        end else if (m_da[c] == m_tgt) begin
          m_ramp[c] = 1'b0;
        end else if (!m_ramp[c] || (m_up[c] != (m_tgt > m_da[c]))) begin
          m_ramp[c] = 1'b1;
          m_up[c] = (m_tgt > m_da[c]);
        end else if (m_rt) begin
          if (m_up[c]) m_da[c] = (m_da[c] + RAMP_STEP > m_tgt) ? m_tgt : m_da[c] + RAMP_STEP;
          else         m_da[c] = (m_da[c] - RAMP_STEP < m_tgt) ? m_tgt : m_da[c] - RAMP_STEP;
          m_ramp[c] = (m_da[c] != m_tgt);
        end
        m_ens[c] = m_meta[c];
        m_meta[c] = int'(enable[c]);
      end
      m_ps = tick && (m_cnt == PERIOD - 1);
      if (tick) m_cnt = (m_cnt + 1) % PERIOD;
      m_presc = m_rt ? 0 : m_presc + 1;
      exp_q.push_back({m_ps, m_ramp, m_pwm});
    end
  end

  // Scoreboard: every cycle's outputs against the model.
  always @(negedge clk) begin
    if (rst_n && exp_q.size() > 0)
      chk("cycle_out", {period_start, ramping, pwm_out}, exp_q.pop_front());
  end

  // ---------------- driver tasks ----------------
  // sel 0: ramping[0], sel 1: period_start
  task automatic wait_for(input int sel, input logic val, input int budget, input string tag);
    logic hit;
    hit = 1'b0;
    for (int k = 0; k < budget && !hit; k++) begin
      @(negedge clk);
      hit = (((sel == 0) ? ramping[0] : period_start) == val);
    end
    chk(tag, hit, 1);
  endtask

  // Samples one period starting at the current negedge (period_start seen).
  task automatic measure(input int chg_at, input logic [RES-1:0] new_d0,
                         output int hi0, output int hi1, output int f0, output int f1);
    hi0 = 0; hi1 = 0; f0 = -1; f1 = -1;
    for (int k = 0; k < PERIOD; k++) begin
      if (k > 0) @(negedge clk);
      if (pwm_out[0]) begin hi0++; if (f0 < 0) f0 = k; end
      if (pwm_out[1]) begin hi1++; if (f1 < 0) f1 = k; end
      if (k == chg_at) duty[RES-1:0] = new_d0;
    end
  endtask

  int hi0, hi1, f0, f1, len;
  logic hit;

  // ---------------- stimulus ----------------
  initial begin
    repeat (3) @(negedge clk);
    chk("rst_pwm", pwm_out, 0);
    chk("rst_ramping", ramping, 0);
    chk("rst_period_start", period_start, 0);
    #2 rst_n = 1'b1;
    tick = 1'b1;

    // Plain PWM, both channels, staggered by half a period.
    duty = {4'd8, 4'd4};
    enable = 2'b11;
    repeat (40) @(negedge clk);
    wait_for(1, 1'b1, 40, "t1_period_start");
    measure(-1, '0, hi0, hi1, f0, f1);
    chk("t1_ch0_high", hi0, 4);
    chk("t1_ch1_high", hi1, 8);
    chk("t1_ch0_first", f0, 0);
    chk("t1_ch1_rise_offset", f1 - f0, 8);

    // Soft start up to full scale.
    enable[0] = 1'b0;
    repeat (5) @(negedge clk);
    soft_start[0] = 1'b1;
    duty[RES-1:0] = 4'd15;
    enable[0] = 1'b1;
    wait_for(0, 1'b1, 10, "t2_ramp_up_start");
    wait_for(0, 1'b0, 60, "t2_ramp_up_end");
    wait_for(1, 1'b1, 20, "t2_period_start");
    measure(-1, '0, hi0, hi1, f0, f1);
    chk("t2_ch0_full", hi0, 16);

    // Soft stop to off.
    enable[0] = 1'b0;
    wait_for(0, 1'b1, 10, "t3_ramp_dn_start");
    wait_for(0, 1'b0, 60, "t3_ramp_dn_end");
    wait_for(1, 1'b1, 20, "t3_period_start");
    measure(-1, '0, hi0, hi1, f0, f1);
    chk("t3_ch0_off", hi0, 0);

    // Mid-period duty change takes effect on the next period only.
    soft_start[0] = 1'b0;
    duty[RES-1:0] = 4'd4;
    enable[0] = 1'b1;
    repeat (40) @(negedge clk);
    wait_for(1, 1'b1, 20, "t4_period_start");
    measure(5, 4'd12, hi0, hi1, f0, f1);
    chk("t4_current_period", hi0, 4);
    wait_for(1, 1'b1, 2, "t4_next_period_start");
    measure(-1, '0, hi0, hi1, f0, f1);
    chk("t4_next_period", hi0, 12);

    // Ramp redirect: ramp toward 15, drop target to 3 at duty_actual 6.
    soft_start[0] = 1'b1;
    enable[0] = 1'b0;
    wait_for(0, 1'b1, 10, "t5_down_start");
    wait_for(0, 1'b0, 60, "t5_down_end");
    duty[RES-1:0] = 4'd15;
    enable[0] = 1'b1;
    hit = 1'b0;
    for (int k = 0; k < 80 && !hit; k++) begin
      @(negedge clk);
      hit = (m_da[0] == 6);
    end
    chk("t5_reach_6", hit, 1);
    duty[RES-1:0] = 4'd3;
    @(negedge clk);
    chk("t5_redirect_ramping", ramping[0], 1);
    wait_for(0, 1'b0, 30, "t5_settle");
    wait_for(1, 1'b1, 20, "t5_period_start");
    measure(-1, '0, hi0, hi1, f0, f1);
    chk("t5_ch0_at_3", hi0, 3);

    // Reset in the middle of a ramp.
    duty[RES-1:0] = 4'd15;
    wait_for(0, 1'b1, 10, "t6_ramp_start");
    repeat (6) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_pwm", pwm_out, 0);
    chk("t6_rst_ramping", ramping, 0);
    chk("t6_rst_period_start", period_start, 0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    wait_for(0, 1'b1, 10, "t6_restart");
    len = 1;
    hit = 1'b0;
    for (int k = 0; k < 80 && !hit; k++) begin
      @(negedge clk);
      if (ramping[0]) len++;
      else hit = 1'b1;
    end
    chk("t6_restart_end", hit, 1);
    chk("t6_ramp_from_zero", len >= 29, 1);

    // Randomized phase, checked by the model every cycle.
    for (int k = 0; k < 600; k++) begin
      @(negedge clk);
      tick = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 7) == 0) duty = NCH*RES'($urandom);
      if ($urandom_range(0, 15) == 0) enable = NCH'($urandom);
      if ($urandom_range(0, 31) == 0) soft_start = NCH'($urandom);
    end
    tick = 1'b1;
    repeat (5) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
